// File: rtl/jbi_jbus_arb_n.sv
// Distributed JBus arbiter for the JBI mout path: round-robin/park arbitration over
// NUM_AGENTS request lines, dead-cycle modes, streaming hold limit and arbitration timeout.
module jbi_jbus_arb_n #(
  parameter int unsigned NUM_AGENTS = 6,
  parameter int unsigned OWN_ID     = 0,
  parameter int unsigned TO_WIDTH   = 32,
  parameter int unsigned HOLD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [1:0]            csr_arb_mode,
  input  logic [HOLD_WIDTH-1:0] csr_hold_limit,
  input  logic                  int_req,
  input  logic                  multiple_in_progress,
  input  logic                  stream_break_point,
  input  logic [NUM_AGENTS-1:0] ext_req_in_l,
  output logic                  req_out_l,
  output logic                  req_out_en,
  output logic                  grant,
  output logic [5:0]            ad_en,
  output logic                  multiple_ok,
  output logic                  parked_on_us,
  output logic                  dsbl_sampling,
  output logic [NUM_AGENTS-1:0] owner,
  input  logic [TO_WIDTH-1:0]   csr_arb_timeval,
  input  logic                  have_trans_waiting,
  input  logic                  piorqq_req,
  input  logic                  int_requestor_piorqq,
  output logic                  err_arb_to,
  output logic [NUM_AGENTS-1:0] log_arb_jreq
);

  localparam int unsigned IDX_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam logic [NUM_AGENTS-1:0] OWN_MASK = NUM_AGENTS'(1) << OWN_ID;

  logic                  int_req_in;
  logic                  int_req_p1_q, int_req_p2_q;
  logic [NUM_AGENTS-1:0] req_vec, grants;
  logic [NUM_AGENTS-1:0] owner_q, owner_d;
  logic [NUM_AGENTS-1:0] log_q;
  logic [IDX_W-1:0]      owner_idx, cand;
  logic                  others_req, nonowner_req, owner_req, rr_found;
  logic                  grant_switch, grant_switch_p1_q;
  logic                  contend, force_off;
  logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic                  arb_to, arb_to_p1_q, to_clr;

  // Own request; reset pulls it off the bus immediately, even mid-packet.
  assign int_req_in = (int_req | multiple_in_progress) & ~force_off & rst_l;
  assign req_out_l  = ~int_req_in;
  assign req_out_en = 1'b1;

  assign req_vec      = (~ext_req_in_l & ~OWN_MASK) | (int_req_p2_q ? OWN_MASK : '0);
  assign others_req   = |(req_vec & ~OWN_MASK);
  assign nonowner_req = |(req_vec & ~owner_q);
  assign owner_req    = |(req_vec & owner_q);

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_AGENTS; i++)
      if (|(owner_q & (NUM_AGENTS'(1) << i))) owner_idx = IDX_W'(i);
  end

  // Next owner: park/keep, else first requester descending circularly from the owner.
  always_comb begin
    grants   = owner_q;
    rr_found = 1'b0;
    cand     = '0;
    if (nonowner_req && !owner_req) begin
      for (int unsigned k = 1; k < NUM_AGENTS; k++) begin
        if (32'(owner_idx) >= k) cand = IDX_W'(32'(owner_idx) - k);
        else                     cand = IDX_W'(32'(owner_idx) + NUM_AGENTS - k);
        if (!rr_found && |(req_vec & (NUM_AGENTS'(1) << cand))) begin
          grants   = NUM_AGENTS'(1) << cand;
          rr_found = 1'b1;
        end
      end
    end
  end

  assign owner_d = grants;

  // Dead-cycle modes only drive once the registered owner is already us.
  assign grant         = |(grants & OWN_MASK) & (csr_arb_mode[1] | |(owner_q & OWN_MASK));
  assign ad_en         = {6{grant}};
  assign grant_switch  = |(grants & ~owner_q);
  assign dsbl_sampling = (csr_arb_mode == 2'b01) & grant_switch_p1_q;
  assign multiple_ok   = grant & int_req_p1_q;
  assign parked_on_us  = |(owner_q & OWN_MASK) & ~others_req;
  assign owner         = owner_q;
  assign log_arb_jreq  = log_q;

  // Fairness release while streaming under contention.
  assign contend    = int_req_p2_q & grant & others_req;
  assign force_off  = contend & stream_break_point & ~multiple_in_progress &
                      (hold_cnt_q >= csr_hold_limit);
  assign hold_cnt_d = !contend ? '0 :
                      (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + HOLD_WIDTH'(1);

  assign arb_to     = (to_cnt_q == csr_arb_timeval);
  assign to_clr     = arb_to | ~have_trans_waiting |
                      (piorqq_req & grant & int_requestor_piorqq) | (~piorqq_req & grant);
  assign to_cnt_d   = to_clr ? '0 : to_cnt_q + TO_WIDTH'(1);
  assign err_arb_to = arb_to_p1_q & ~arb_to;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      int_req_p1_q      <= 1'b0;
      int_req_p2_q      <= 1'b0;
      owner_q           <= OWN_MASK;
      grant_switch_p1_q <= 1'b0;
      hold_cnt_q        <= '0;
      to_cnt_q          <= '0;
      arb_to_p1_q       <= 1'b0;
      log_q             <= '0;
    end else begin
      int_req_p1_q      <= int_req_in;
      int_req_p2_q      <= int_req_p1_q;
      owner_q           <= owner_d;
      grant_switch_p1_q <= grant_switch;
      hold_cnt_q        <= hold_cnt_d;
      to_cnt_q          <= to_cnt_d;
      arb_to_p1_q       <= arb_to;
      log_q             <= req_vec;
    end
  end

endmodule

// File: tb/tb_jbi_jbus_arb_n.sv
// Bench for jbi_jbus_arb_n (6 agents, own ID 0): directed scenarios plus random traffic,
// all checked against an index-level behavioural model of the arbitration rules.
module tb_jbi_jbus_arb_n;
  localparam int NA  = 6;
  localparam int OWN = 0;

  logic        clk;
  logic        rst_l;
  logic [1:0]  mode;
  logic [7:0]  limit;
  logic        int_req, mip, sbp;
  logic [5:0]  ext_l;
  logic        req_out_l, req_out_en, grant, multiple_ok, parked_on_us, dsbl_sampling;
  logic [5:0]  ad_en, owner, log_arb_jreq;
  logic [31:0] timeval;
  logic        htw, pio, ireq_pio, err_arb_to;

  jbi_jbus_arb_n #(.NUM_AGENTS(NA), .OWN_ID(OWN), .TO_WIDTH(32), .HOLD_WIDTH(8)) dut (
    .clk(clk), .rst_l(rst_l), .csr_arb_mode(mode), .csr_hold_limit(limit),
    .int_req(int_req), .multiple_in_progress(mip), .stream_break_point(sbp),
    .ext_req_in_l(ext_l), .req_out_l(req_out_l), .req_out_en(req_out_en),
    .grant(grant), .ad_en(ad_en), .multiple_ok(multiple_ok), .parked_on_us(parked_on_us),
    .dsbl_sampling(dsbl_sampling), .owner(owner), .csr_arb_timeval(timeval),
    .have_trans_waiting(htw), .piorqq_req(pio), .int_requestor_piorqq(ireq_pio),
    .err_arb_to(err_arb_to), .log_arb_jreq(log_arb_jreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model state: owner as an agent index, request pipeline, counters as integers.
  int          m_owner, m_hold;
  bit          m_p1, m_p2, m_gsw, m_ato;
  logic [31:0] m_to;
  logic [5:0]  m_log;
  int          n_owner, n_hold;
  bit          n_irq, n_ato;
  logic [31:0] n_to;
  logic [5:0]  n_req;
  bit          obs_grant, obs_dsbl, obs_rol, obs_err;

  task automatic model_reset();
    m_owner = OWN; m_hold = 0; m_p1 = 0; m_p2 = 0; m_gsw = 0; m_ato = 0;
    m_to = '0; m_log = '0;
  endtask

  task automatic eval_and_check();
    logic [5:0] req;
    bit others, found, e_grant, contend, fo, arb_to, clr;
    int c;
    req = ~ext_l;
    req[OWN] = m_p2;
    others = 0;
    for (int i = 0; i < NA; i++) if (i != OWN && req[i]) others = 1;
    n_owner = m_owner;
    found = 0;
    if (!req[m_owner]) begin
      for (int d = 1; d < NA; d++) begin
        c = (m_owner - d + NA) % NA;
        if (!found && req[c]) begin n_owner = c; found = 1; end
      end
    end
    e_grant = (n_owner == OWN) && (mode[1] || m_owner == OWN);
    contend = m_p2 && e_grant && others;
    fo      = contend && sbp && !mip && (m_hold >= int'(limit));
    n_irq   = (int_req || mip) && !fo;
    arb_to  = (m_to == timeval);
    clr     = arb_to || !htw || (pio && e_grant && ireq_pio) || (!pio && e_grant);

    chk("grant",        32'(grant),         32'(e_grant));
    chk("ad_en",        32'(ad_en),         e_grant ? 32'h3f : 32'h0);
    chk("req_out_l",    32'(req_out_l),     32'(!n_irq));
    chk("req_out_en",   32'(req_out_en),    32'h1);
    chk("multiple_ok",  32'(multiple_ok),   32'(e_grant && m_p1));
    chk("parked_on_us", 32'(parked_on_us),  32'(m_owner == OWN && !others));
    chk("dsbl_sampling",32'(dsbl_sampling), 32'(mode == 2'b01 && m_gsw));
    chk("owner",        32'(owner),         32'(6'b1 << m_owner));
    chk("err_arb_to",   32'(err_arb_to),    32'(m_ato && !arb_to));
    chk("log_arb_jreq", 32'(log_arb_jreq),  32'(m_log));

    obs_grant = grant; obs_dsbl = dsbl_sampling; obs_rol = req_out_l; obs_err = err_arb_to;
    n_hold = !contend ? 0 : (m_hold < 255 ? m_hold + 1 : 255);
    n_to   = clr ? 32'h0 : m_to + 32'h1;
    n_ato  = arb_to;
    n_req  = req;
  endtask

  task automatic commit();
    m_p2 = m_p1; m_p1 = n_irq;
    m_gsw = (n_owner != m_owner);
    m_owner = n_owner; m_hold = n_hold; m_to = n_to; m_ato = n_ato; m_log = n_req;
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_l = 1'b1;
  endtask

  task automatic idle_inputs();
    int_req = 0; mip = 0; sbp = 0; ext_l = '1; htw = 0; pio = 0; ireq_pio = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [4:0] gseq, dseq;
    int first, cnt;
    idle_inputs();
    mode = 2'b00; limit = 8'd0; timeval = 32'd10; rst_l = 1'b0;
    model_reset();
    #12;
    chk("rst_grant",   32'(grant),        32'h1);
    chk("rst_parked",  32'(parked_on_us), 32'h1);
    chk("rst_owner",   32'(owner),        32'h01);
    chk("rst_req_l",   32'(req_out_l),    32'h1);
    chk("rst_err",     32'(err_arb_to),   32'h0);
    chk("rst_mok",     32'(multiple_ok),  32'h0);
    @(posedge clk); #1;
    rst_l = 1'b1;

    // Round robin 0 -> 5 -> 3 -> 0 with a dead cycle, in modes 00 and 01.
    for (int md = 0; md < 2; md++) begin
      idle_inputs(); mode = 2'(md);
      do_reset();
      int_req = 1; repeat (3) cycle();
      int_req = 0; ext_l = ~6'b101000; repeat (4) cycle();
      chk("rr_own5", 32'(owner), 32'h20);
      ext_l = ~6'b001000; repeat (3) cycle();
      chk("rr_own3", 32'(owner), 32'h08);
      ext_l = '1; int_req = 1;
      for (int i = 0; i < 5; i++) begin cycle(); gseq[i] = obs_grant; dseq[i] = obs_dsbl; end
      chk("dead_gnt_seq", 32'(gseq), 32'h18);
      chk("dsbl_seq",     32'(dseq), (md == 1) ? 32'h08 : 32'h00);
    end

    // Mode 10: ownership 4 -> 0 with no dead cycle.
    idle_inputs(); mode = 2'b10;
    do_reset();
    ext_l = ~6'b010000; repeat (2) cycle();
    chk("nd_own4", 32'(owner), 32'h10);
    ext_l = '1; int_req = 1;
    for (int i = 0; i < 4; i++) begin cycle(); gseq[i] = obs_grant; end
    chk("nodead_gnt_seq", 32'(gseq[3:0]), 32'hc);

    // Hold limit 4 with agent 2 contending; then multiple_in_progress keeps request.
    idle_inputs(); mode = 2'b10; limit = 8'd4; sbp = 1;
    do_reset();
    int_req = 1; repeat (3) cycle();
    ext_l = ~6'b000100; first = -1;
    for (int i = 0; i < 8; i++) begin cycle(); if (obs_rol && first < 0) first = i; end
    chk("hold_release_idx", 32'(first), 32'd4);
    idle_inputs(); sbp = 1; mip = 1;
    do_reset();
    int_req = 1; repeat (3) cycle();
    ext_l = ~6'b000100; cnt = 0;
    for (int i = 0; i < 10; i++) begin cycle(); cnt += int'(obs_rol); end
    chk("mip_hold_low", 32'(cnt), 32'd0);

    // Arbitration timeout, never granted.
    idle_inputs(); mode = 2'b00; limit = 8'd0; timeval = 32'd10;
    htw = 1; ext_l = ~6'b000010;
    do_reset();
    first = -1; cnt = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (obs_err) begin cnt++; if (first < 0) first = i; end
    end
    chk("to_first_pulse", 32'(first), 32'd11);
    chk("to_pulse_count", 32'(cnt), 32'd2);

    // Reset asserted mid multi-cycle packet.
    idle_inputs(); mode = 2'b00;
    do_reset();
    int_req = 1; mip = 1; repeat (4) cycle();
    chk("pkt_mok_pre", 32'(multiple_ok), 32'h1);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_grant",  32'(grant),       32'h1);
    chk("arst_mok",    32'(multiple_ok), 32'h0);
    chk("arst_req_l",  32'(req_out_l),   32'h1);
    chk("arst_owner",  32'(owner),       32'h01);
    ext_l = ~6'b001000;
    #1;
    chk("arst_grant_other", 32'(grant), 32'h0);
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    rst_l = 1'b1;

    // Random traffic against the model.
    for (int blk = 0; blk < 8; blk++) begin
      mode    = 2'($urandom_range(0, 3));
      limit   = 8'($urandom_range(0, 6));
      timeval = 32'($urandom_range(3, 40));
      if (blk == 4) do_reset();
      for (int i = 0; i < 100; i++) begin
        for (int b = 0; b < NA; b++)
          if ($urandom_range(0, 99) < 30) ext_l[b] = ~ext_l[b];
        int_req  = ($urandom_range(0, 99) < 60);
        mip      = ($urandom_range(0, 99) < 15);
        sbp      = ($urandom_range(0, 99) < 50);
        htw      = ($urandom_range(0, 99) < 90);
        pio      = ($urandom_range(0, 99) < 50);
        ireq_pio = ($urandom_range(0, 99) < 50);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
